// File: rtl/ddr4_odt_sched.sv
// ODT window scheduler and IOD delay-line sequencer; optional tap tracking under DDR4_ODT_TAP_TRACK_EN.
// Latency: slot p of a cycle-n command appears in cycle n+1+floor(p/4); delay pulses are registered (1 cycle).
// Backpressure: none on commands; DLY_REQ while DLY_BUSY is dropped without queueing.
module ddr4_odt_sched #(
    parameter int MAX_LAT   = 63,
    parameter int MAX_WIDTH = 15,
    parameter int TAP_W     = 7
) (
    input  logic             FAB_CLK,
    input  logic             ARST_N,
    input  logic             WR_CMD_VALID,
    input  logic [1:0]       WR_CMD_PHASE,
    input  logic [5:0]       CFG_ODT_LAT,
    input  logic [3:0]       CFG_ODT_WIDTH,
    input  logic             ODT_FORCE,
    output logic [3:0]       TX_DATA,
    output logic [3:0]       OE_DATA,
    input  logic             DLY_REQ,
    input  logic             DLY_RELOAD,
    input  logic             DLY_DIR,
    input  logic [TAP_W-1:0] DLY_TAPS,
    output logic             DLY_BUSY,
    output logic             DLY_ACK,
    output logic             DLY_ERR,
    output logic [7:0]       DLY_POS,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    output logic             DELAY_LINE_LOAD,
    input  logic             DELAY_LINE_OUT_OF_RANGE
);
    localparam int DEPTH = 4 * ((3 + MAX_LAT + MAX_WIDTH + 3) / 4);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_MOVE, S_GAP, S_LOADP, S_DONE} dly_state_t;

    logic [DEPTH-1:0] sched_q, sched_d, win_mask, merged;
    logic [6:0]       win_start;
    logic [3:0]       tx_q, oe_q;

    dly_state_t       state_q, state_d;
    logic [TAP_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;
    logic             move_q, load_q, ack_q, busy_q;

    // The window is placed relative to slot 0 of the command's cycle; bits 0..3
    // are consumed immediately, so slot p lands floor(p/4) shifts later.
    always_comb begin
        win_start = 7'(WR_CMD_PHASE) + 7'(CFG_ODT_LAT);
        win_mask  = '0;
        if (WR_CMD_VALID)
            win_mask = ((DEPTH'(1) << CFG_ODT_WIDTH) - DEPTH'(1)) << win_start;
        merged  = sched_q | win_mask;
        sched_d = merged >> 4;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (DLY_REQ) begin
                    if (DLY_RELOAD) begin
                        state_d = S_LOADP;
                    end else begin
                        state_d = S_SETUP;
                        cnt_d   = DLY_TAPS;
                        dir_d   = DLY_DIR;
                    end
                end
            end
            S_SETUP: state_d = (cnt_q == '0) ? S_DONE : S_MOVE;
            S_MOVE: begin
                cnt_d   = cnt_q - TAP_W'(1);
                state_d = S_GAP;
            end
            S_GAP: begin
                if (DELAY_LINE_OUT_OF_RANGE) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = (cnt_q != '0) ? S_MOVE : S_DONE;
                end
            end
            S_LOADP: begin
                err_d   = 1'b0;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pulse outputs are decoded from the next state so they are flops aligned with the state.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            sched_q <= '0;
            tx_q    <= 4'h0;
            oe_q    <= 4'h0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
            move_q  <= 1'b0;
            load_q  <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sched_q <= sched_d;
            tx_q    <= ODT_FORCE ? 4'hF : merged[3:0];
            oe_q    <= 4'hF;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
            move_q  <= (state_d == S_MOVE);
            load_q  <= (state_d == S_LOADP);
            ack_q   <= (state_d == S_DONE);
            busy_q  <= (state_d != S_IDLE);
        end
    end

`ifdef DDR4_ODT_TAP_TRACK_EN
    logic [7:0] pos_q, pos_d;

    // A move is credited only once its GAP cycle confirms the line stayed in range.
    always_comb begin
        pos_d = pos_q;
        if (state_q == S_LOADP) begin
            pos_d = 8'h00;
        end else if (state_q == S_GAP && !DELAY_LINE_OUT_OF_RANGE) begin
            if (dir_q && pos_q != 8'hFF)
                pos_d = pos_q + 8'h01;
            else if (!dir_q && pos_q != 8'h00)
                pos_d = pos_q - 8'h01;
        end
    end

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) pos_q <= 8'h00;
        else         pos_q <= pos_d;
    end

    assign DLY_POS = pos_q;
`else
    assign DLY_POS = 8'h00;
`endif

    assign TX_DATA              = tx_q;
    assign OE_DATA              = oe_q;
    assign DLY_BUSY             = busy_q;
    assign DLY_ACK              = ack_q;
    assign DLY_ERR              = err_q;
    assign DELAY_LINE_MOVE      = move_q;
    assign DELAY_LINE_DIRECTION = dir_q;
    assign DELAY_LINE_LOAD      = load_q;
endmodule
